// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg
//   Shared constants for the multi-cycle instruction sequencer: FSM state
//   encodings, pc_sel codes, decoder pc_control codes, branch opcodes, and
//   helpers that classify an opcode and resolve a conditional branch.
package cpu_seq_pkg;

  // FSM state encodings (3'd7 is illegal and recovers to IDLE)
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEMORY    = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  // PC source select
  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd1;
  localparam logic [1:0] PC_SEL_REG    = 2'd2;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd3;

  // Decoder pc_control codes
  localparam logic [3:0] PC_CTRL_SEQ    = 4'd0;
  localparam logic [3:0] PC_CTRL_JUMP   = 4'd1;
  localparam logic [3:0] PC_CTRL_JR     = 4'd2;
  localparam logic [3:0] PC_CTRL_BRANCH = 4'd3;

  // Conditional branch opcodes
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef struct packed {
    logic is_mem;
    logic is_load;
    logic is_store;
  } op_class_t;

  // Memory ops have op[5] set; op[3] separates stores from loads.
  function automatic op_class_t classify(input logic [5:0] op);
    op_class_t c;
    c.is_mem   = op[5];
    c.is_load  = op[5] & ~op[3];
    c.is_store = op[5] &  op[3];
    return c;
  endfunction

  function automatic logic branch_taken(input logic [5:0] op, input logic zero);
    return ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer
//   Counts consecutive not-ready cycles of a memory handshake and pulses
//   timeout on the cycle the limit is reached while still not ready.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clear_i    : restart the count (entry into a waiting state)
//   count_en_i : a wait cycle is happening now (in a waiting state, ready low)
//   timeout_o  : combinational pulse, this wait cycle is the last one allowed
module seq_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic timeout_o
);

  // count_q holds the number of wait cycles already seen, so the
  // TIMEOUT_CYCLES-th wait cycle is the one where count_q == limit-1.
  localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  assign timeout_o = count_en_i & (count_q == LAST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle sequencer for the simplified MIPS CPU. Owns the instruction
//   register, walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, gates decoder
//   write enables into their own phase, issues one PC update per retired
//   instruction and traps memory stalls into a sticky ERROR state.
//   Inputs : clk, rst (async, active high), run, imem_rdata/imem_ready,
//            dmem_ready, dec_data_mem_wren, dec_reg_file_wren,
//            dec_pc_control, alu_zero
//   Outputs: instruction, imem_req, dmem_req, data_mem_wren, reg_file_wren,
//            pc_wren, pc_sel, state, bus_error, instr_retired
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic [3:0]  dec_data_mem_wren,
  input  logic        dec_reg_file_wren,
  input  logic [3:0]  dec_pc_control,
  input  logic        alu_zero,
  output logic [31:0] instruction,
  output logic        imem_req,
  output logic        dmem_req,
  output logic [3:0]  data_mem_wren,
  output logic        reg_file_wren,
  output logic        pc_wren,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        bus_error,
  output logic [31:0] instr_retired
);

  logic [2:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q;
  logic        bus_error_q, bus_error_d;

  logic [5:0]  op;
  op_class_t   op_cls;
  logic [2:0]  retire_next;
  logic        waiting;
  logic        timer_clear;
  logic        timeout;

  assign op     = instr_q[31:26];
  assign op_cls = classify(op);

  // After a retiring cycle, run decides whether the next instruction starts.
  assign retire_next = run ? ST_FETCH : ST_IDLE;

  assign waiting = ((state_q == ST_FETCH)  & ~imem_ready) |
                   ((state_q == ST_MEMORY) & ~dmem_ready);

  // Restart on entry only; MEMORY -> FETCH is a direct edge, so compare states.
  assign timer_clear = (state_d != state_q) &
                       ((state_d == ST_FETCH) | (state_d == ST_MEMORY));

  seq_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clear),
    .count_en_i (waiting),
    .timeout_o  (timeout)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    bus_error_d   = bus_error_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    data_mem_wren = 4'b0000;
    reg_file_wren = 1'b0;
    pc_wren       = 1'b0;
    pc_sel        = PC_SEL_SEQ;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        // Ready on the limit cycle wins over the timeout.
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d     = ST_ERROR;
          bus_error_d = 1'b1;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        if (op_cls.is_mem) begin
          state_d = ST_MEMORY;
        end else if (dec_pc_control != PC_CTRL_SEQ) begin
          pc_wren = 1'b1;
          state_d = retire_next;
          case (dec_pc_control)
            PC_CTRL_JUMP:   pc_sel = PC_SEL_JUMP;
            PC_CTRL_JR:     pc_sel = PC_SEL_REG;
            PC_CTRL_BRANCH: pc_sel = branch_taken(op, alu_zero) ? PC_SEL_BRANCH : PC_SEL_SEQ;
            default:        pc_sel = PC_SEL_SEQ;
          endcase
        end else if (dec_reg_file_wren) begin
          state_d = ST_WRITEBACK;
        end else begin
          pc_wren = 1'b1;
          state_d = retire_next;
        end
      end

      ST_MEMORY: begin
        dmem_req = 1'b1;
        if (op_cls.is_store) data_mem_wren = dec_data_mem_wren;
        if (dmem_ready) begin
          if (op_cls.is_load) begin
            state_d = ST_WRITEBACK;
          end else begin
            pc_wren = 1'b1;
            state_d = retire_next;
          end
        end else if (timeout) begin
          state_d     = ST_ERROR;
          bus_error_d = 1'b1;
        end
      end

      ST_WRITEBACK: begin
        reg_file_wren = dec_reg_file_wren;
        pc_wren       = 1'b1;
        state_d       = retire_next;
      end

      ST_ERROR: begin
        state_d = ST_ERROR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      retired_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      bus_error_q <= bus_error_d;
      if (pc_wren) retired_q <= retired_q + 32'd1;
    end
  end

  assign instruction   = instr_q;
  assign state         = state_q;
  assign bus_error     = bus_error_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Directed bench for cpu_sequencer. For each instruction the bench builds
//   the expected cycle-by-cycle phase list (fetch waits, decode, execute,
//   memory waits, writeback) from the instruction class, then one compare
//   loop drives the per-cycle handshakes and checks every output. Literal
//   latencies, pc_sel values and retire counts pin the model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_ready;
  logic [3:0]  dec_data_mem_wren;
  logic        dec_reg_file_wren;
  logic [3:0]  dec_pc_control;
  logic        alu_zero;
  logic [31:0] instruction;
  logic        imem_req;
  logic        dmem_req;
  logic [3:0]  data_mem_wren;
  logic        reg_file_wren;
  logic        pc_wren;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        bus_error;
  logic [31:0] instr_retired;

  cpu_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .run               (run),
    .imem_rdata        (imem_rdata),
    .imem_ready        (imem_ready),
    .dmem_ready        (dmem_ready),
    .dec_data_mem_wren (dec_data_mem_wren),
    .dec_reg_file_wren (dec_reg_file_wren),
    .dec_pc_control    (dec_pc_control),
    .alu_zero          (alu_zero),
    .instruction       (instruction),
    .imem_req          (imem_req),
    .dmem_req          (dmem_req),
    .data_mem_wren     (data_mem_wren),
    .reg_file_wren     (reg_file_wren),
    .pc_wren           (pc_wren),
    .pc_sel            (pc_sel),
    .state             (state),
    .bus_error         (bus_error),
    .instr_retired     (instr_retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One expected cycle: inputs to drive plus outputs required.
  typedef struct {
    logic        run;
    logic        iready;
    logic        dready;
    logic [2:0]  st;
    logic        ireq;
    logic        dreq;
    logic [3:0]  dwren;
    logic        rfw;
    logic        pcw;
    logic [1:0]  psel;
    logic        berr;
    logic [31:0] ir;
  } cyc_t;

  cyc_t        q[$];
  int          exp_retired = 0;
  logic [31:0] exp_ir = 32'h0;

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c.run = 1'b1; c.iready = 1'b1; c.dready = 1'b1; c.st = st;
    c.ireq = 1'b0; c.dreq = 1'b0; c.dwren = 4'h0; c.rfw = 1'b0;
    c.pcw = 1'b0; c.psel = 2'd0; c.berr = 1'b0; c.ir = exp_ir;
    return c;
  endfunction

  // Drive and check up to n queued cycles (0 = all); measures the DUT
  // latency from the first non-IDLE cycle to the first pc_wren.
  task automatic play(input int n, output int lat, output logic [1:0] psel_seen);
    cyc_t c;
    int   k;
    bit   done;
    k = 0; lat = 0; psel_seen = 2'd0; done = 0;
    while (q.size() > 0 && (n == 0 || k < n)) begin
      c = q.pop_front();
      run = c.run; imem_ready = c.iready; dmem_ready = c.dready;
      @(negedge clk);
      chk("state",         {29'd0, state},         {29'd0, c.st});
      chk("imem_req",      {31'd0, imem_req},      {31'd0, c.ireq});
      chk("dmem_req",      {31'd0, dmem_req},      {31'd0, c.dreq});
      chk("data_mem_wren", {28'd0, data_mem_wren}, {28'd0, c.dwren});
      chk("reg_file_wren", {31'd0, reg_file_wren}, {31'd0, c.rfw});
      chk("pc_wren",       {31'd0, pc_wren},       {31'd0, c.pcw});
      chk("pc_sel",        {30'd0, pc_sel},        {30'd0, c.psel});
      chk("bus_error",     {31'd0, bus_error},     {31'd0, c.berr});
      chk("instruction",   instruction,            c.ir);
      chk("instr_retired", instr_retired,          exp_retired);
      if (!done && state != 3'd0) lat++;
      if (!done && pc_wren) begin done = 1; psel_seen = pc_sel; end
      if (c.pcw) exp_retired++;
      @(posedge clk); #1;
      k++;
    end
    q.delete();
  endtask

  task automatic idle_cycles(input int n, input logic r);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(3'd0);
      c.run = r;
      q.push_back(c);
    end
  endtask

  // Expected phase list for one instruction from its class and handshakes.
  task automatic instr(input logic [31:0] word, input logic [3:0] dmw, input logic rfw,
                       input logic [3:0] pcc, input logic az, input int iwait,
                       input int dwait, input bit stop, input int n_play,
                       output int lat, output logic [1:0] ps);
    cyc_t       c;
    logic [5:0] op;
    bit         is_mem, is_load, is_store, taken, needs_wb;
    op       = word[31:26];
    is_mem   = op[5];
    is_load  = op[5] & ~op[3];
    is_store = op[5] & op[3];
    taken    = (op == 6'b000100 && az) || (op == 6'b000101 && !az);
    needs_wb = is_load || (!is_mem && pcc == 4'd0 && rfw);
    imem_rdata = word; dec_data_mem_wren = dmw; dec_reg_file_wren = rfw;
    dec_pc_control = pcc; alu_zero = az;

    for (int i = 0; i <= iwait; i++) begin
      c = blank(3'd1);
      c.ireq = 1'b1;
      c.iready = (i == iwait);
      q.push_back(c);
    end
    exp_ir = word;
    q.push_back(blank(3'd2));
    c = blank(3'd3);
    if (!is_mem) begin
      if (pcc != 4'd0) begin
        c.pcw  = 1'b1;
        c.psel = (pcc == 4'd1) ? 2'd1 : (pcc == 4'd2) ? 2'd2 : (taken ? 2'd3 : 2'd0);
      end else if (!rfw) begin
        c.pcw = 1'b1;
      end
    end
    q.push_back(c);
    if (is_mem) begin
      for (int i = 0; i <= dwait; i++) begin
        c = blank(3'd4);
        c.dreq   = 1'b1;
        c.dwren  = is_store ? dmw : 4'h0;
        c.dready = (i == dwait);
        c.pcw    = (i == dwait) && !is_load;
        q.push_back(c);
      end
    end
    if (needs_wb) begin
      c = blank(3'd5);
      c.rfw = rfw;
      c.pcw = 1'b1;
      q.push_back(c);
    end
    if (stop) begin
      foreach (q[i]) if (q[i].st >= (is_mem ? 3'd4 : 3'd3)) q[i].run = 1'b0;
    end
    play(n_play, lat, ps);
    $display("instr 0x%08h: latency %0d cycles, pc_sel %0d, retired %0d", word, lat, ps, instr_retired);
  endtask

  int         lat;
  logic [1:0] ps;

  initial begin
    rst = 1'b1; run = 1'b0; imem_rdata = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0;
    dec_data_mem_wren = 4'h0; dec_reg_file_wren = 1'b0; dec_pc_control = 4'h0; alu_zero = 1'b0;
    #12;
    chk("rst_state",     {29'd0, state}, 32'd0);
    chk("rst_instr",     instruction, 32'd0);
    chk("rst_retired",   instr_retired, 32'd0);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    chk("rst_strobes",   {24'd0, imem_req, dmem_req, data_mem_wren, pc_wren, reg_file_wren}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    idle_cycles(1, 1'b1);
    play(0, lat, ps);

    // R-type add
    instr(32'h012A4020, 4'h0, 1'b1, 4'd0, 1'b0, 0, 0, 0, 0, lat, ps);
    chk("rtype_latency", lat, 32'd4);
    chk("rtype_retired", instr_retired, 32'd1);
    // store word, 3 dmem wait cycles
    instr(32'hAD280004, 4'hF, 1'b0, 4'd0, 1'b0, 0, 3, 0, 0, lat, ps);
    chk("store_latency", lat, 32'd7);
    // BEQ taken, BNE not taken
    instr(32'h11090003, 4'h0, 1'b0, 4'd3, 1'b1, 0, 0, 0, 0, lat, ps);
    chk("beq_latency", lat, 32'd3);
    chk("beq_pc_sel", {30'd0, ps}, 32'd3);
    instr(32'h15090003, 4'h0, 1'b0, 4'd3, 1'b1, 0, 0, 0, 0, lat, ps);
    chk("bne_pc_sel", {30'd0, ps}, 32'd0);
    // jump, jump register
    instr(32'h08000010, 4'h0, 1'b0, 4'd1, 1'b0, 0, 0, 0, 0, lat, ps);
    chk("j_pc_sel", {30'd0, ps}, 32'd1);
    instr(32'h01000008, 4'h0, 1'b0, 4'd2, 1'b0, 0, 0, 0, 0, lat, ps);
    chk("jr_pc_sel", {30'd0, ps}, 32'd2);
    // load with fetch and memory waits
    instr(32'h8D280004, 4'h0, 1'b1, 4'd0, 1'b0, 2, 1, 0, 0, lat, ps);
    chk("load_latency", lat, 32'd8);
    // ready arriving on the 16th wait-window cycle does not trap
    instr(32'h21280005, 4'h0, 1'b1, 4'd0, 1'b0, 15, 0, 0, 0, lat, ps);
    chk("fetch_limit_latency", lat, 32'd19);
    instr(32'h8D280008, 4'h0, 1'b1, 4'd0, 1'b0, 0, 15, 0, 0, lat, ps);
    // run dropped during a load's memory phase: finishes, then stays idle
    instr(32'h8D28000C, 4'h0, 1'b1, 4'd0, 1'b0, 0, 0, 1, 0, lat, ps);
    idle_cycles(3, 1'b0);
    play(0, lat, ps);
    chk("stop_retired", instr_retired, 32'd10);

    // fetch timeout: 16 low cycles then sticky ERROR, run toggling ignored
    begin
      cyc_t c;
      idle_cycles(1, 1'b1);
      for (int i = 0; i < 16; i++) begin
        c = blank(3'd1); c.ireq = 1'b1; c.iready = 1'b0; q.push_back(c);
      end
      for (int i = 0; i < 4; i++) begin
        c = blank(3'd6); c.berr = 1'b1; c.iready = 1'b0; c.run = i[0]; q.push_back(c);
      end
      play(0, lat, ps);
    end
    $display("timeout: state %0d bus_error %0d", state, bus_error);
    rst = 1'b1; #1;
    chk("err_rst_state", {29'd0, state}, 32'd0);
    chk("err_rst_bus_error", {31'd0, bus_error}, 32'd0);
    chk("err_rst_retired", instr_retired, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_retired = 0; exp_ir = 32'h0;

    // reset during a store's memory phase
    idle_cycles(1, 1'b1);
    play(0, lat, ps);
    instr(32'hAD2C0010, 4'hF, 1'b0, 4'd0, 1'b0, 0, 3, 0, 3, lat, ps);
    dmem_ready = 1'b0; #1;
    chk("mem_wren_before_rst", {28'd0, data_mem_wren}, 32'hF);
    rst = 1'b1; #1;
    chk("mem_rst_wren", {28'd0, data_mem_wren}, 32'd0);
    chk("mem_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("mem_rst_state", {29'd0, state}, 32'd0);
    chk("mem_rst_instr", instruction, 32'd0);
    $display("reset in memory: state %0d instruction 0x%08h", state, instruction);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer for the simplified MIPS CPU.
- Owns the instruction register and steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Gates the combinational decoder's write enables (`data_mem_wren`, `reg_file_wren`) so each takes effect only in its own phase.
- Handshakes with instruction and data memory, issues exactly one PC update per retired instruction, and traps memory stalls longer than a set limit.

Parameters:
- `TIMEOUT_CYCLES`, 16, maximum wait cycles in FETCH or MEMORY before trapping to ERROR.
- `TO_W`, 5, width of the wait counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  start/continue execution; sampled at instruction boundaries.
- `imem_rdata`  in  32  instruction memory read data.
- `imem_ready`  in  1  instruction memory data valid this cycle.
- `dmem_ready`  in  1  data memory access complete this cycle.
- `dec_data_mem_wren`  in  4  byte-lane enables from the decoder.
- `dec_reg_file_wren`  in  1  register-write request from the decoder.
- `dec_pc_control`  in  4  0 = sequential, 1 = jump, 2 = jump register, 3 = branch.
- `alu_zero`  in  1  ALU zero flag, valid in EXECUTE.
- `instruction`  out  32  instruction register; feeds the decoder.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data memory access request.
- `data_mem_wren`  out  4  gated byte-lane write enables.
- `reg_file_wren`  out  1  gated register file write enable.
- `pc_wren`  out  1  one-cycle PC update strobe.
- `pc_sel`  out  2  0 = PC+4, 1 = jump target, 2 = register, 3 = branch target.
- `state`  out  3  current FSM state, for debug.
- `bus_error`  out  1  sticky timeout flag.
- `instr_retired`  out  32  count of retired instructions.

Behaviour:
- Reset (asynchronous, `rst`=1):
  - state = IDLE; `instruction` = 0; `instr_retired` = 0; wait counter = 0; `bus_error` = 0.
  - Every output strobe and request is 0.
  - `rst` asserted mid-instruction aborts it immediately: no write or PC strobe fires on the reset edge.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=6. Encoding 7 is illegal and returns to IDLE.
- Outputs are decoded from the registered state plus the listed inputs only. No outputs are driven in IDLE, DECODE or ERROR.
- Opcode `op` = `instruction[31:26]`:
  - is_mem = `op[5]`.
  - is_load = `op[5]` & ~`op[3]`.
  - is_store = `op[5]` & `op[3]`.
- IDLE: `run`=1 -> FETCH.
- FETCH:
  - `imem_req`=1.
  - `imem_ready`=1 -> `instruction` <= `imem_rdata`, next DECODE.
- DECODE: single cycle -> EXECUTE.
- EXECUTE (single cycle):
  - is_mem -> MEMORY.
  - else `dec_pc_control`!=0 -> `pc_wren`=1, next FETCH/IDLE. `pc_sel`:
    - 1 -> 1; 2 -> 2.
    - 3 -> 3 if (`op`=000100 & `alu_zero`) | (`op`=000101 & ~`alu_zero`), else 0.
  - else `dec_reg_file_wren`=1 -> WRITEBACK.
  - else `pc_wren`=1, `pc_sel`=0, next FETCH/IDLE.
- MEMORY:
  - `dmem_req`=1; `data_mem_wren` = `dec_data_mem_wren` if is_store, else 0.
  - `dmem_ready`=1 -> is_load -> WRITEBACK; else `pc_wren`=1, `pc_sel`=0, next FETCH/IDLE.
- WRITEBACK (single cycle):
  - `reg_file_wren` = `dec_reg_file_wren`.
  - `pc_wren`=1, `pc_sel`=0, next FETCH/IDLE.
- FETCH/IDLE resolution: FETCH if `run`=1, else IDLE. A deasserted `run` therefore completes the current instruction before stopping.
- Wait counter:
  - Cleared on entry to FETCH or MEMORY; increments each cycle the ready input is low.
  - Reaching `TIMEOUT_CYCLES` with ready low -> ERROR, `bus_error` <= 1.
  - Ready high on the limit cycle wins (no error).
- ERROR: absorbing until `rst`. `bus_error` held at 1, all strobes 0.
- `instr_retired` increments on every `pc_wren` and wraps 0xFFFFFFFF -> 0.
- Latency with zero-wait memory:
  - Branch/jump: 3 cycles.
  - R-type, immediate ops, store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1 cycle.

Decomposition:
- Package `cpu_seq_pkg`: state encodings, `pc_sel` codes, BEQ/BNE opcode constants, `pc_control` codes.
- Sub-module `seq_wait_timer`: clear, count-enable and limit compare, producing a `timeout` pulse.
- FSM, instruction register and retire counter stay in `cpu_sequencer`.

Test Plan:
- R-type add (0x012A4020), `imem_ready` tied 1, `dec_reg_file_wren`=1 -> states 1,2,3,5; `reg_file_wren`=1 exactly in cycle 4; `pc_wren`=1 with `pc_sel`=0 in cycle 4; `instr_retired`=1.
- Store word (op 101011), `dec_data_mem_wren`=1111, `dmem_ready` low 3 cycles -> `data_mem_wren`=1111 for all 4 MEMORY cycles; `reg_file_wren` never 1; one `pc_wren`.
- BEQ with `alu_zero`=1 -> `pc_sel`=3 in EXECUTE, total 3 cycles. BNE with `alu_zero`=1 -> `pc_sel`=0.
- `imem_ready` held low -> ERROR after 16 FETCH cycles; `bus_error`=1 sticky; `run` toggling has no effect; `rst` clears it. `imem_ready` rising on cycle 16 -> no error.
- `rst` asserted in MEMORY of a store -> `data_mem_wren` drops to 0 asynchronously; state=0; `instruction`=0.
- `run` dropped during a load's MEMORY phase -> load completes with WRITEBACK and `pc_wren`, then IDLE; no further `imem_req`.
